stk_engine: RTL

Stack responder that executes PUSH/POP commands encoded with the `stk_pkg::opcode_t` values, holding up to `N` entries of `W` bits. It sits at the far end of the `stk` command interface: it accepts one command per valid/ready handshake and returns exactly one response per accepted command, in order. Overflow, underflow and illegal opcodes produce error responses and leave the stack state unchanged.

---
 rtl/stk_pkg.sv | 29 ++
 rtl/stk_mem.sv | 27 ++
 rtl/stk_engine.sv | 118 +++++++++++
 3 files changed

// File: rtl/stk_pkg.sv
// Shared types for the stk command interface: opcodes, error flag and response layout.
package stk_pkg;

    localparam int STK_W_DEFAULT = 32;
    localparam int STK_N_DEFAULT = 16;

    typedef enum logic [1:0] {
        OP_ILL0 = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_ILL3 = 2'b11
    } opcode_t;

    typedef enum logic {
        ERR_NONE   = 1'b0,
        ERR_REJECT = 1'b1
    } err_t;

    typedef struct packed {
        opcode_t                  opcode;
        err_t                     err;
        logic [STK_W_DEFAULT-1:0] dat;
    } rsp_t;

    function automatic logic opcode_is_legal(opcode_t op);
        return (op == OP_PUSH) || (op == OP_POP);
    endfunction

endpackage

// File: rtl/stk_mem.sv
// N x W flop array with one synchronous write port and one combinational read port.
module stk_mem #(
    parameter int W  = 32,
    parameter int N  = 16,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_dat
);

    logic [W-1:0] mem_q [N];

    // NOTE: storage has no reset; an entry is only read after it was written,
    // so clearing it would cost a reset net on every bit for no behavioural gain.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/stk_engine.sv
// Stack responder: executes PUSH/POP commands and returns one in-order response per accepted command.
module stk_engine
    import stk_pkg::*;
#(
    parameter int W = STK_W_DEFAULT,
    parameter int N = STK_N_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_vld,
    input  logic [1:0]             cmd_opcode,
    input  logic [W-1:0]           cmd_dat,
    output logic                   cmd_rdy,
    output logic                   rsp_vld,
    output logic [1:0]             rsp_opcode,
    output logic [W-1:0]           rsp_dat,
    output logic                   rsp_err,
    input  logic                   rsp_rdy,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(N+1)-1:0] cnt
);

    localparam int CW = $clog2(N+1);
    localparam int AW = $clog2(N);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RSP  = 1'b1
    } state_t;

    typedef struct packed {
        opcode_t      opcode;
        err_t         err;
        logic [W-1:0] dat;
    } rsp_w_t;

    state_t        state_q, state_d;
    rsp_w_t        rsp_q, rsp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          accept;
    logic          mem_wr_en;
    logic [AW-1:0] mem_rd_addr;
    logic [W-1:0]  mem_rd_dat;
    opcode_t       op_in;

    assign op_in       = opcode_t'(cmd_opcode);
    assign full        = (cnt_q == CW'(N));
    assign empty       = (cnt_q == '0);
    assign cmd_rdy     = (state_q == S_IDLE) | rsp_rdy;
    assign accept      = cmd_vld & cmd_rdy;
    assign mem_rd_addr = AW'(cnt_q - CW'(1));

    stk_mem #(
        .W  (W),
        .N  (N),
        .AW (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (cnt_q[AW-1:0]),
        .wr_dat  (cmd_dat),
        .rd_addr (mem_rd_addr),
        .rd_dat  (mem_rd_dat)
    );

    // NOTE: every signal assigned here gets its default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        rsp_d     = rsp_q;
        cnt_d     = cnt_q;
        mem_wr_en = 1'b0;

        if (accept) begin
            state_d      = S_RSP;
            rsp_d.opcode = op_in;
            rsp_d.err    = ERR_REJECT;
            rsp_d.dat    = '0;
            if (opcode_is_legal(op_in)) begin
                if (op_in == OP_PUSH && !full) begin
                    mem_wr_en = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                    rsp_d.err = ERR_NONE;
                    rsp_d.dat = cmd_dat;
                end else if (op_in == OP_POP && !empty) begin
                    cnt_d     = cnt_q - CW'(1);
                    rsp_d.err = ERR_NONE;
                    rsp_d.dat = mem_rd_dat;
                end
            end
        end else if (state_q == S_RSP && rsp_rdy) begin
            state_d = S_IDLE;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rsp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_vld    = (state_q == S_RSP);
    assign rsp_opcode = rsp_q.opcode;
    assign rsp_err    = rsp_q.err;
    assign rsp_dat    = rsp_q.dat;
    assign cnt        = cnt_q;

endmodule
